// File: rtl/div_arbiter.sv
// Round-robin front end sharing one divider between two requesters.
// Optional zero-divisor bypass enabled by defining DIV_ZERO_BYPASS_EN.
module div_arbiter #(
  parameter int DVD_W          = 32,
  parameter int DVS_W          = 16,
  parameter int RES_W          = 17,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DVD_W-1:0] req0_dividend,
  input  logic [DVS_W-1:0] req0_divisor,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DVD_W-1:0] req1_dividend,
  input  logic [DVS_W-1:0] req1_divisor,
  input  logic             req1_mode,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [RES_W-1:0] resp_data,
  output logic             resp_err,
  output logic [DVD_W-1:0] div_dividend,
  output logic [DVS_W-1:0] div_divisor,
  output logic             div_mode,
  output logic             div_valid_input,
  input  logic             div_valid_output,
  input  logic [RES_W-1:0] div_final_output,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic             mode_q, mode_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant0, grant1;
  logic             accept;
  logic [DVD_W-1:0] sel_dvd;
  logic [DVS_W-1:0] sel_dvs;
  logic             sel_mode;
  logic             own_ready;

`ifdef DIV_ZERO_BYPASS_EN
  localparam logic [RES_W-1:0] QPOS = RES_W'({DVS_W{1'b1}});
  localparam logic [RES_W-1:0] QNEG = -QPOS;
`endif

  // Contention goes to whoever did not win last.
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  assign sel_dvd   = grant0 ? req0_dividend : req1_dividend;
  assign sel_dvs   = grant0 ? req0_divisor  : req1_divisor;
  assign sel_mode  = grant0 ? req0_mode     : req1_mode;
  assign own_ready = owner_q ? resp1_ready  : resp0_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    mode_d  = mode_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dvd_d   = sel_dvd;
          dvs_d   = sel_dvs;
          mode_d  = sel_mode;
          owner_d = grant1;
          state_d = ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
          if (sel_dvs == '0) begin
            err_d   = 1'b1;
            state_d = RESP;
            if (sel_mode)
              res_d = sel_dvd[DVD_W-1] ? QNEG : QPOS;
            else
              res_d = sel_dvd[RES_W-1:0];
          end
`endif
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_valid_output) begin
          res_d   = div_final_output;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (own_ready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      dvd_q   <= '0;
      dvs_q   <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign div_dividend    = dvd_q;
  assign div_divisor     = dvs_q;
  assign div_mode        = mode_q;
  assign div_valid_input = (state_q == ISSUE);
  assign busy            = (state_q != IDLE);
  assign resp0_valid     = (state_q == RESP) & ~owner_q;
  assign resp1_valid     = (state_q == RESP) & owner_q;
  assign resp_data       = (state_q == RESP) ? res_q : '0;
  assign resp_err        = (state_q == RESP) & err_q;

endmodule
